// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the LEGv8 multi-cycle control unit: FSM states, opcodes,
// datapath select codes, control-word layout and the instruction decoder.
package legv8_ctrl_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_BRANCH = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    typedef enum logic [3:0] {
        INS_ADD, INS_SUB, INS_AND, INS_ORR, INS_ADDS, INS_SUBS,
        INS_ADDI, INS_SUBI, INS_ANDI, INS_ORRI,
        INS_LDUR, INS_STUR, INS_CBZ, INS_CBNZ, INS_B, INS_ILLEGAL
    } ins_t;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_D, IMM_B, IMM_CB} imm_class_t;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [9:0]  OP_ANDI = 10'b1001001000;
    localparam logic [9:0]  OP_ORRI = 10'b1011001000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [5:0]  OP_B    = 6'b000101;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;

    localparam logic [1:0] PS_HOLD   = 2'b00;
    localparam logic [1:0] PS_INC    = 2'b01;
    localparam logic [1:0] PS_LOAD   = 2'b10;
    localparam logic [1:0] PS_BRANCH = 2'b11;

    localparam logic [1:0] BUS_NONE = 2'b00;
    localparam logic [1:0] BUS_RF   = 2'b01;
    localparam logic [1:0] BUS_MEM  = 2'b11;
    localparam logic [1:0] SIZE_DW  = 2'b11;

    localparam int CW_ADDR_SEL  = 33;
    localparam int CW_BUS_LSB   = 31;
    localparam int CW_PS_LSB    = 29;
    localparam int CW_PC_LD     = 28;
    localparam int CW_B_SEL     = 27;
    localparam int CW_IR_LD     = 26;
    localparam int CW_SL        = 25;
    localparam int CW_FS_LSB    = 20;
    localparam int CW_C0        = 19;
    localparam int CW_SIZE_LSB  = 17;
    localparam int CW_MEM_WRITE = 16;
    localparam int CW_REG_WRITE = 15;
    localparam int CW_DA_LSB    = 10;
    localparam int CW_SA_LSB    = 5;
    localparam int CW_SB_LSB    = 0;

    typedef struct packed {
        logic       addr_sel;
        logic [1:0] bus_sel;
        logic [1:0] ps;
        logic       pc_ld;
        logic       b_sel;
        logic       ir_ld;
        logic       sl;
        logic [4:0] fs;
        logic       c0;
        logic [1:0] size;
        logic       mem_write;
        logic       reg_write;
        logic [4:0] da;
        logic [4:0] sa;
        logic [4:0] sb;
    } cw_t;

    // Longest opcode wins: 11-bit forms are tried before the shorter prefixes.
    function automatic ins_t decode_ins(input logic [31:0] ir);
        ins_t r;
        r = INS_ILLEGAL;
        case (ir[31:21])
            OP_ADD:  r = INS_ADD;
            OP_SUB:  r = INS_SUB;
            OP_AND:  r = INS_AND;
            OP_ORR:  r = INS_ORR;
            OP_ADDS: r = INS_ADDS;
            OP_SUBS: r = INS_SUBS;
            OP_LDUR: r = INS_LDUR;
            OP_STUR: r = INS_STUR;
            default: begin
                case (ir[31:22])
                    OP_ADDI: r = INS_ADDI;
                    OP_SUBI: r = INS_SUBI;
                    OP_ANDI: r = INS_ANDI;
                    OP_ORRI: r = INS_ORRI;
                    default: begin
                        case (ir[31:24])
                            OP_CBZ:  r = INS_CBZ;
                            OP_CBNZ: r = INS_CBNZ;
                            default: if (ir[31:26] == OP_B) r = INS_B;
                        endcase
                    end
                endcase
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/legv8_imm_gen.sv
// Combinational immediate extraction for the datapath constant input.
// Branch offsets are pre-biased by -4 since PC has already advanced in DECODE.
module legv8_imm_gen
    import legv8_ctrl_pkg::*;
(
    input  logic [25:0] ir,
    input  imm_class_t  imm_class,
    output logic [63:0] imm
);

    always_comb begin
        imm = '0;
        case (imm_class)
            IMM_I:   imm = {52'd0, ir[21:10]};
            IMM_D:   imm = {{55{ir[20]}}, ir[20:12]};
            IMM_B:   imm = {{36{ir[25]}}, ir[25:0], 2'b00} - 64'd4;
            IMM_CB:  imm = {{43{ir[23]}}, ir[23:5], 2'b00} - 64'd4;
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 control FSM: Moore control word/constant from state and held IR;
// only the CB branch decision looks at ALU status combinationally, in EXEC.
module legv8_control_unit
    import legv8_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR_in,
    input  logic [4:0]  status,
    output logic [33:0] ControlWord,
    output logic [63:0] constant,
    output logic [2:0]  state,
    output logic        halted
);

    logic [2:0]  st;
    logic [2:0]  nxt;
    ins_t        ins;
    imm_class_t  imm_class;
    cw_t         cw;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic        taken;
    logic        status_unused;

    assign ins = decode_ins(IR_in);
    assign rd  = IR_in[4:0];
    assign rn  = IR_in[9:5];
    assign rm  = IR_in[20:16];
    assign taken = ((ins == INS_CBZ) && status[0]) || ((ins == INS_CBNZ) && !status[0]);
    assign status_unused = ^status[4:1];

    always_ff @(posedge clock) begin
        if (!reset) st <= ST_FETCH;
        else        st <= nxt;
    end

    always_comb begin
        cw        = '0;
        imm_class = IMM_NONE;
        nxt       = st;
        case (st)
            ST_FETCH: begin
                cw.addr_sel = 1'b1;
                cw.bus_sel  = BUS_MEM;
                cw.ir_ld    = 1'b1;
                cw.size     = SIZE_DW;
                nxt         = ST_DECODE;
            end
            ST_DECODE: begin
                cw.pc_ld = 1'b1;
                cw.ps    = PS_INC;
                cw.size  = SIZE_DW;
                if (ins == INS_B)            nxt = ST_BRANCH;
                else if (ins == INS_ILLEGAL) nxt = ST_HALT;
                else                         nxt = ST_EXEC;
            end
            ST_EXEC, ST_MEM: begin
                cw.size = SIZE_DW;
                nxt     = ST_FETCH;
                case (ins)
                    INS_ADD, INS_ADDS, INS_ADDI, INS_LDUR, INS_STUR: cw.fs = FS_ADD;
                    INS_SUB, INS_SUBS, INS_SUBI: begin
                        cw.fs = FS_SUB;
                        cw.c0 = 1'b1;
                    end
                    INS_AND, INS_ANDI: cw.fs = FS_AND;
                    default:           cw.fs = FS_ORR;
                endcase
                case (ins)
                    INS_ADD, INS_SUB, INS_AND, INS_ORR, INS_ADDS, INS_SUBS: begin
                        cw.da        = rd;
                        cw.sa        = rn;
                        cw.sb        = rm;
                        cw.reg_write = 1'b1;
                        cw.sl        = (ins == INS_ADDS) || (ins == INS_SUBS);
                    end
                    INS_ADDI, INS_SUBI, INS_ANDI, INS_ORRI: begin
                        cw.da        = rd;
                        cw.sa        = rn;
                        cw.b_sel     = 1'b1;
                        cw.reg_write = 1'b1;
                        imm_class    = IMM_I;
                    end
                    INS_LDUR: begin
                        // MEM replays the address phase so the load data stays on the bus.
                        cw.sa      = rn;
                        cw.b_sel   = 1'b1;
                        cw.bus_sel = BUS_MEM;
                        imm_class  = IMM_D;
                        if (st == ST_MEM) begin
                            cw.reg_write = 1'b1;
                            cw.da        = rd;
                        end else begin
                            nxt = ST_MEM;
                        end
                    end
                    INS_STUR: begin
                        cw.sa        = rn;
                        cw.sb        = rd;
                        cw.b_sel     = 1'b1;
                        cw.bus_sel   = BUS_RF;
                        cw.mem_write = 1'b1;
                        imm_class    = IMM_D;
                    end
                    INS_CBZ, INS_CBNZ: begin
                        cw.sa = 5'd31;
                        cw.sb = rd;
                        nxt   = taken ? ST_BRANCH : ST_FETCH;
                    end
                    default: nxt = ST_HALT;
                endcase
            end
            ST_BRANCH: begin
                cw.pc_ld  = 1'b1;
                cw.ps     = PS_BRANCH;
                cw.size   = SIZE_DW;
                imm_class = (ins == INS_B) ? IMM_B : IMM_CB;
                nxt       = ST_FETCH;
            end
            ST_HALT: nxt = ST_HALT;
            default: nxt = ST_FETCH;
        endcase
    end

    legv8_imm_gen u_imm_gen (
        .ir        (IR_in[25:0]),
        .imm_class (imm_class),
        .imm       (imm)
    );

    // Outputs are forced quiet while reset is held so an abandoned instruction issues nothing.
    assign ControlWord = reset ? cw  : '0;
    assign constant    = reset ? imm : '0;
    assign state       = st;
    assign halted      = (st == ST_HALT);

endmodule

// File: tb/tb_legv8_control_unit.sv
// Randomized self-checking bench for legv8_control_unit against a per-mnemonic cycle model.
module tb_legv8_control_unit;

    localparam int S_FETCH  = 0;
    localparam int S_DECODE = 1;
    localparam int S_EXEC   = 2;
    localparam int S_MEM    = 3;
    localparam int S_BRANCH = 4;
    localparam int S_HALT   = 5;

    logic        clock;
    logic        reset;
    logic [31:0] IR_in;
    logic [4:0]  status;
    logic [33:0] ControlWord;
    logic [63:0] constant;
    logic [2:0]  state;
    logic        halted;

    int n_chk;
    int n_fail;

    int          q_st[$];
    logic [33:0] q_cw[$];
    logic [63:0] q_k[$];

    // Kinds: 0 ADD 1 SUB 2 AND 3 ORR 4 ADDS 5 SUBS 6 ADDI 7 SUBI 8 ANDI 9 ORRI
    //        10 LDUR 11 STUR 12 CBZ 13 CBNZ 14 B 15 raw illegal word
    int unsigned opc[15] = '{'b10001011000, 'b11001011000, 'b10001010000, 'b10101010000,
                             'b10101011000, 'b11101011000, 'b1001000100, 'b1101000100,
                             'b1001001000, 'b1011001000, 'b11111000010, 'b11111000000,
                             'b10110100, 'b10110101, 'b000101};
    int fsv[15] = '{8, 9, 0, 4, 8, 9, 8, 9, 0, 4, 8, 8, 4, 4, 0};
    int c0v[15] = '{0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};

    legv8_control_unit dut (
        .clock       (clock),
        .reset       (reset),
        .IR_in       (IR_in),
        .status      (status),
        .ControlWord (ControlWord),
        .constant    (constant),
        .state       (state),
        .halted      (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] mk(int addr, int bus, int ps, int pcld, int bsel, int irld,
                                       int sl, int fs, int c0, int memw, int regw,
                                       int da, int sa, int sb);
        return (34'(addr) << 33) | (34'(bus) << 31) | (34'(ps) << 29) | (34'(pcld) << 28)
             | (34'(bsel) << 27) | (34'(irld) << 26) | (34'(sl) << 25) | (34'(fs) << 20)
             | (34'(c0) << 19) | (34'(3) << 17) | (34'(memw) << 16) | (34'(regw) << 15)
             | (34'(da) << 10) | (34'(sa) << 5) | 34'(sb);
    endfunction

    function automatic logic [63:0] sx(longint v, int bits);
        longint r;
        r = v & ((longint'(1) << bits) - 1);
        if (r >= (longint'(1) << (bits - 1))) r = r - (longint'(1) << bits);
        return 64'(r);
    endfunction

    task automatic push(int s, logic [33:0] w, logic [63:0] k);
        q_st.push_back(s);
        q_cw.push_back(w);
        q_k.push_back(k);
    endtask

    task automatic build(input int k, input int rd, input int rn, input int rm,
                         input int unsigned imm, input bit z, output logic [31:0] ir);
        logic [31:0] junk;
        logic [63:0] dk;
        bit          tk;
        q_st.delete(); q_cw.delete(); q_k.delete();
        junk = 32'($urandom);
        push(S_FETCH,  mk(1, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 64'd0);
        push(S_DECODE, mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 64'd0);
        dk = sx(longint'(imm), 9);
        ir = '0;
        if (k <= 5) begin
            ir = (32'(opc[k]) << 21) | (32'(rm) << 16) | ((junk & 32'h3F) << 10)
               | (32'(rn) << 5) | 32'(rd);
            push(S_EXEC, mk(0, 0, 0, 0, 0, 0, (k == 4 || k == 5) ? 1 : 0, fsv[k], c0v[k],
                            0, 1, rd, rn, rm), 64'd0);
        end else if (k <= 9) begin
            ir = (32'(opc[k]) << 22) | ((imm & 32'hFFF) << 10) | (32'(rn) << 5) | 32'(rd);
            push(S_EXEC, mk(0, 0, 0, 0, 1, 0, 0, fsv[k], c0v[k], 0, 1, rd, rn, 0),
                 64'(imm & 32'hFFF));
        end else if (k == 10) begin
            ir = (32'(opc[k]) << 21) | ((imm & 32'h1FF) << 12) | ((junk & 32'h3) << 10)
               | (32'(rn) << 5) | 32'(rd);
            push(S_EXEC, mk(0, 3, 0, 0, 1, 0, 0, 8, 0, 0, 0, 0,  rn, 0), dk);
            push(S_MEM,  mk(0, 3, 0, 0, 1, 0, 0, 8, 0, 0, 1, rd, rn, 0), dk);
        end else if (k == 11) begin
            ir = (32'(opc[k]) << 21) | ((imm & 32'h1FF) << 12) | ((junk & 32'h3) << 10)
               | (32'(rn) << 5) | 32'(rd);
            push(S_EXEC, mk(0, 1, 0, 0, 1, 0, 0, 8, 0, 1, 0, 0, rn, rd), dk);
        end else if (k <= 13) begin
            ir = (32'(opc[k]) << 24) | ((imm & 32'h7FFFF) << 5) | 32'(rd);
            push(S_EXEC, mk(0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 31, rd), 64'd0);
            tk = (k == 12) ? z : !z;
            if (tk)
                push(S_BRANCH, mk(0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                     sx(longint'(imm), 19) * 4 - 4);
        end else if (k == 14) begin
            ir = (32'(opc[k]) << 26) | (imm & 32'h3FFFFFF);
            push(S_BRANCH, mk(0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                 sx(longint'(imm), 26) * 4 - 4);
        end else begin
            ir = imm;
            for (int h = 0; h < 3; h++) push(S_HALT, 34'd0, 64'd0);
        end
    endtask

    // Runs one instruction through the model; abort_at >= 0 asserts reset at that cycle.
    task automatic run(input int k, input int rd, input int rn, input int rm,
                       input int unsigned imm, input bit z, input int abort_at);
        logic [31:0] ir;
        logic [31:0] rnd;
        build(k, rd, rn, rm, imm, z, ir);
        for (int i = 0; i < q_st.size(); i++) begin
            IR_in  = (q_st[i] == S_FETCH) ? 32'($urandom) : ir;
            rnd    = 32'($urandom);
            status = {rnd[3:0], z};
            if (i == abort_at) begin
                reset = 1'b0;
                #1;
                chk($sformatf("k%0d_rst_cw", k), 64'(ControlWord), 64'd0);
                chk($sformatf("k%0d_rst_k", k), constant, 64'd0);
                @(posedge clock); #1;
                chk($sformatf("k%0d_rst_state", k), 64'(state), 64'(S_FETCH));
                chk($sformatf("k%0d_rst_halted", k), 64'(halted), 64'd0);
                reset = 1'b1;
                return;
            end
            #1;
            chk($sformatf("k%0d_c%0d_state", k, i), 64'(state), 64'(q_st[i]));
            chk($sformatf("k%0d_c%0d_cw", k, i), 64'(ControlWord), 64'(q_cw[i]));
            chk($sformatf("k%0d_c%0d_const", k, i), constant, q_k[i]);
            chk($sformatf("k%0d_c%0d_halted", k, i), 64'(halted), 64'(q_st[i] == S_HALT));
            @(posedge clock); #1;
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b0;
        IR_in  = 32'hFFFF_FFFF;
        status = 5'd0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clock); #1;
            chk("reset_state", 64'(state), 64'(S_FETCH));
            chk("reset_cw", 64'(ControlWord), 64'd0);
            chk("reset_const", constant, 64'd0);
            chk("reset_halted", 64'(halted), 64'd0);
        end
        reset = 1'b1;

        run(6, 0, 31, 0, 24, 1'b0, -1);
        run(11, 1, 31, 0, 8, 1'b0, -1);
        run(10, 2, 31, 0, 8, 1'b0, -1);
        run(12, 3, 0, 0, 4, 1'b1, -1);
        run(12, 3, 0, 0, 4, 1'b0, -1);
        run(13, 3, 0, 0, 4, 1'b0, -1);
        run(13, 3, 0, 0, 4, 1'b1, -1);
        run(14, 0, 0, 0, 32'h3FFFFFE, 1'b0, -1);
        run(0, 31, 1, 2, 0, 1'b0, -1);
        run(10, 31, 4, 0, 32'h1F0, 1'b0, -1);
        run(15, 0, 0, 0, 32'h0000_0000, 1'b0, 4);
        run(15, 0, 0, 0, 32'hFFFF_FFFF, 1'b0, 4);
        run(10, 5, 6, 0, 32'h1F0, 1'b0, 3);
        run(11, 7, 8, 0, 32'h010, 1'b0, 2);

        for (int n = 0; n < 300; n++) begin
            run(int'($urandom_range(0, 14)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                $urandom, 1'($urandom_range(0, 1)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/legv8_control_unit.md
# legv8_control_unit

Multi-cycle control unit for the LEGv8 datapath. It accepts the fetched instruction register and the ALU status from the datapath. It generates the 34-bit control word and the 64-bit immediate constant, so the datapath runs programs without a bench driving control words. The block sits directly upstream of the datapath's ControlWord and constant inputs.

## Interface
- No parameters; all encodings are fixed in the shared package.
- clock  in  1  rising-edge clock, shared with the datapath.
- reset  in  1  synchronous, active-low.
- IR_in  in  32  instruction from the datapath IR output.
- status  in  5  combinational ALU status of the current cycle: [0] Z, [1] N, [2] C, [3] V, [4] unused.
- ControlWord  out  34  datapath control word.
- constant  out  64  immediate to the datapath constant input.
- state  out  3  current FSM state, for debug.
- halted  out  1  high in HALT.

## Operation
- ControlWord fields, MSB to LSB:
  - [33] addr_sel: 1 = PC drives address.
  - [32:31] bus_sel: 00 none, 01 RF-B drives data, 11 memory drives data.
  - [30:29] PS: 00 hold, 01 PC+4, 10 load, 11 PC+constant.
  - [28] pc_ld, [27] B_sel (constant), [26] IR_ld, [25] SL.
  - [24:20] FS: AND 00000, ORR 00100, ADD 01000, SUB 01001 (with C0=1).
  - [19] C0, [18:17] size (always 11), [16] mem_write, [15] reg_write.
  - [14:10] DA, [9:5] SA, [4:0] SB.
- States: FETCH, DECODE, EXEC, MEM, BRANCH, HALT.
- FETCH: addr_sel=1, bus_sel=11, IR_ld=1. Next state DECODE.
- DECODE: pc_ld=1, PS=01. Next state:
  - BRANCH for B.
  - HALT for an unsupported opcode.
  - EXEC otherwise.
- EXEC, by instruction:
  - R-type ADD/SUB/AND/ORR/ADDS/SUBS: DA=Rd, SA=Rn, SB=Rm, reg_write=1. SL=1 only for ADDS/SUBS. Next state FETCH.
  - I-type ADDI/SUBI/ANDI/ORRI: B_sel=1, constant = zext(imm12 [21:10]). Next state FETCH.
  - LDUR: SA=Rn, B_sel=1, FS ADD, bus_sel=11, reg_write=0. Next state MEM.
  - STUR: SA=Rn, SB=Rt, B_sel=1, FS ADD, bus_sel=01, mem_write=1. Next state FETCH.
  - CBZ/CBNZ: SA=31, SB=Rt, FS ORR, SL=0. If status[0] matches (Z=1 for CBZ, Z=0 for CBNZ), next state BRANCH; otherwise FETCH.
- MEM (LDUR only): the EXEC word is repeated with reg_write=1 and DA=Rt. Next state FETCH.
- BRANCH: pc_ld=1, PS=11.
  - constant = (sext(imm) << 2) − 4, because PC was already advanced in DECODE.
  - Immediate is imm26 [25:0] for B, imm19 [23:5] for CB-type.
  - Next state FETCH.
- HALT: ControlWord all zero. The block stays in HALT until reset.
- Opcode matching:
  - 11-bit opcodes: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, ADDS 10101011000, SUBS 11101011000, LDUR 11111000010, STUR 11111000000.
  - 10-bit: ADDI 1001000100, SUBI 1101000100, ANDI 1001001000, ORRI 1011001000.
  - 8-bit: CBZ 10110100, CBNZ 10110101. 6-bit: B 000101.
- D-type constant = sext(imm9 [20:12]).
- All other constants are 0.

## Timing
- ControlWord and constant are Moore outputs, decoded from the state and the held IR. The one exception is the CB branch decision, which samples status combinationally during EXEC.
- Per-instruction cycles, including FETCH:
  - 3 cycles: R, I, STUR, B, and CB not-taken.
  - 4 cycles: LDUR and CB taken.
- Reset low at a clock edge: next state FETCH; ControlWord and constant are 0; state=FETCH; halted=0.
  - An instruction in flight is abandoned; no partial write is issued after that edge.
- IR_in is used only from DECODE onward. The value present during FETCH is ignored.
- Rd/Rt = 31 with reg_write is passed through unchanged; the datapath discards writes to XZR.

## Structure
- Package legv8_ctrl_pkg holds:
  - the state enum;
  - opcode constants;
  - FS and PS codes;
  - ControlWord field bit positions;
  - a packed struct for the control word.
- Sub-module legv8_imm_gen: combinational immediate extraction and sign-extension from IR and instruction class. The FSM stays in the top module.

## Test plan
- Reset: hold reset low for 2 cycles, then release. Required: ControlWord=0 and constant=0 throughout reset; state sequence FETCH then DECODE.
- ADDI X0, XZR, #24 (0x910063E0): EXEC ControlWord has DA=0, SA=31, B_sel=1, FS=01000, reg_write=1, constant=24. Returns to FETCH after 3 cycles.
- STUR X1, [XZR,#8] then LDUR X2, [XZR,#8]:
  - STUR EXEC: mem_write=1, SB=1, constant=8.
  - LDUR: EXEC has reg_write=0, MEM has reg_write=1 with DA=2.
  - Total 7 cycles.
- CBZ X3, +4 instructions:
  - With status[0]=1 in EXEC: BRANCH with PS=11, constant=12.
  - With status[0]=0: FETCH directly after EXEC.
- B −2 (imm26 = 0x3FFFFFE): constant=0xFFFFFFFFFFFFFFF4, PS=11, pc_ld=1 in BRANCH.
- Illegal opcode 0x00000000: HALT reached after DECODE, halted=1, ControlWord=0. Asserting reset returns the block to FETCH.
